oled_numfield: RTL and testbench
================================

# oled_numfield

Parametrised OLED numeric-field renderer: converts a binary value to DIGITS decimal glyphs, with optional leading-zero blanking and overflow saturation. It emits the complete SSD1306 page/column/data word stream for an 8x16 font over two pages, one 24-bit word per IIC transfer. It sits between the sensor front-ends (DHT11 and similar) and the shared IIC writer in the OLED subsystem, and replaces the fixed 3-glyph temperature renderer. Glyph bitmaps come from an external registered font ROM.

## Interface
- DIGITS, 3: glyph count, 1..6.
- VAL_W, 10: value width, 1..20.
- X0, 54: column of the leftmost glyph, 0..127.
- GAP, 0: blank columns between glyphs.
- PAGE, 3: top page, 0..6. The glyph occupies PAGE and PAGE+1.
- BLANK_LZ, 1: when 1, leading zeros are blanked. The LS digit is always drawn.
- Elaboration check: X0 + DIGITS*(8+GAP) - GAP <= 128.

Ports:
- sys_clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- value_vld  in  1  one-cycle strobe; loads value into the shadow register.
- value  in  VAL_W  unsigned binary value.
- show_req  in  1  level request from the OLED sequencer.
- write_done  in  1  one-cycle pulse from the IIC writer when a word has been sent.
- show_vld  out  1  high while show_data is a valid transfer word (SEND state).
- show_data  out  24  {addr, ctrl, byte}.
- show_finish  out  1  one-cycle pulse; the frame is complete.
- glyph_code  out  4  to font ROM: 0-9 are digits, 10 is blank.
- glyph_row  out  1  to font ROM: 0 = upper page, 1 = lower page.
- glyph_col  out  3  to font ROM: column 0..7.
- glyph_byte  in  8  from font ROM, registered, 1-cycle latency.

## Operation
- **Shadow register**
  - value_vld loads shadow <= value at any time.
  - A frame uses a snapshot taken at frame start.
  - If value_vld and frame start coincide, the snapshot is the new value (bypass).
- **IDLE**
  - show_vld = 0.
  - show_req = 1 takes the snapshot and goes to CONV.
- **CONV**
  - Sequential double-dabble in bin2bcd_seq, VAL_W cycles, then DONE.
  - If the value exceeds 10^DIGITS - 1, all digits are forced to 9.
  - Leading-zero mask: with BLANK_LZ = 1, a digit is blank when it and all more-significant digits are 0, except digit 0. Blank digits have glyph_code = 10.
  - Then go to SEND.
- **SEND**
  - Iterates glyph d = DIGITS-1 down to 0, i.e. left to right.
  - For each glyph: row 0, then row 1.
  - For each row: word index w = 0..10.
    - w0 = {78,00,B0+PAGE+row}
    - w1 = {78,00,00+x[3:0]}
    - w2 = {78,00,10+x[6:4]}
    - w3..w10 = {78,40,glyph_byte}, with glyph_col = w-3
  - Column: x = X0 + (DIGITS-1-d)*(8+GAP).
  - Each write_done advances w. Wrap order: w 10 -> 0 with row 0 -> 1; row 1 -> 0 with the next glyph.
  - The write_done on the last word (d = 0, row 1, w10) pulses show_finish and returns to IDLE.
- **Boundary behaviour**
  - write_done is ignored outside SEND.
  - show_req is not sampled during CONV or SEND. Dropping it mid-frame does not abort the frame.
  - If show_req is still high in IDLE after show_finish, a new frame starts the next cycle.
  - value_vld during CONV or SEND updates only the shadow; the frame in progress is unaffected.
  - Reset mid-frame immediately returns to IDLE. The next frame restarts at glyph DIGITS-1, row 0, w0.
- **Output reset values:** show_vld 0, show_data 24'h780000, show_finish 0, glyph_code 0, glyph_row 0, glyph_col 0.

## Timing
- show_req sampled at cycle t gives show_vld = 1 at t + VAL_W + 2.
- The word index advances on the cycle after write_done.
- glyph_byte, and therefore show_data, is valid 1 cycle later (ROM latency).
- The IIC writer must not sample show_data earlier than 2 cycles after write_done. The existing writer's start latency satisfies this.
- show_finish is combinational with the final write_done: the same cycle.
- Frame length: DIGITS*22 transfers.

## Structure
- **oled_pkg:**
  - OLED_ADDR = 8'h78
  - CTRL_CMD = 8'h00
  - CTRL_DATA = 8'h40
  - CMD_PAGE = 8'hB0
  - CMD_COL_LO = 8'h00
  - CMD_COL_HI = 8'h10
  - GLYPH_W = 8
  - WORDS_PER_ROW = 11
  - GLYPH_BLANK = 4'd10
  - state enum {IDLE, CONV, SEND}
- **Sub-module bin2bcd_seq:** parameters VAL_W and DIGITS; ports start, bin, done, bcd[4*DIGITS-1:0], ovf.

## Test plan
- **Normal frame:** DIGITS = 3, X0 = 54, PAGE = 3, value 25, show_req held. Required response:
  - 66 words.
  - Glyph 2 blank, with w1/w2 = 06/13.
  - Glyph 1 '2', x = 62: w0 = B3, then w0 = B4 on row 1.
  - Glyph 0 '5', x = 70.
  - A single show_finish pulse.
- **Zero and no blanking:** value 0 gives glyphs {10,10,0}. With BLANK_LZ = 0 and value 7, glyphs are {0,0,7}.
- **Overflow and full width:** value 1500 with DIGITS = 3 gives {9,9,9}. Value 999 gives {9,9,9} through the normal path, with no saturation.
- **Shadow update:**
  - value_vld = 123 during SEND: the current frame still shows the snapshot; the next frame shows 123.
  - value_vld coincident with frame start: that frame shows the new value.
- **Reset mid-frame:** assert rst_n low at word 30. Outputs go to their reset values; the next frame starts at w0 = B3, glyph DIGITS-1.
- **Spurious write_done:** pulses in IDLE and CONV leave the word index at 0 and produce no show_finish.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants and types for the OLED numeric-field renderer.
//   OLED_ADDR / CTRL_*   : SSD1306 IIC address and control bytes
//   CMD_*                : page / column-address command bases
//   GLYPH_W, WORDS_PER_ROW, GLYPH_BLANK : glyph geometry and blank code
//   state_t              : renderer sequencing states
package oled_pkg;

    localparam logic [7:0] OLED_ADDR  = 8'h78;
    localparam logic [7:0] CTRL_CMD   = 8'h00;
    localparam logic [7:0] CTRL_DATA  = 8'h40;
    localparam logic [7:0] CMD_PAGE   = 8'hB0;
    localparam logic [7:0] CMD_COL_LO = 8'h00;
    localparam logic [7:0] CMD_COL_HI = 8'h10;

    localparam int         GLYPH_W       = 8;
    localparam int         WORDS_PER_ROW = 11;
    localparam logic [3:0] GLYPH_BLANK   = 4'd10;

    typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
//   sys_clk, rst_n : clock, asynchronous active-low reset (control only)
//   start          : one-cycle strobe, captures bin
//   bin            : unsigned binary input
//   done           : one-cycle pulse, VAL_W+1 cycles after start
//   bcd            : DIGITS packed BCD digits, digit 0 in bits [3:0]
//   ovf            : value did not fit in DIGITS decimal digits
module bin2bcd_seq #(
    parameter int VAL_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [VAL_W-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [CNT_W-1:0]    cnt;
    logic                busy;
    logic [VAL_W-1:0]    bin_sr;
    logic [4*DIGITS-1:0] bcd_sr;
    logic [4*DIGITS-1:0] bcd_adj;
    logic                ovf_r;

    function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] b);
        logic [4*DIGITS-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj = add3(bcd_sr);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                cnt  <= CNT_W'(VAL_W);
            end else if (busy) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // A set MSB in the top digit after the +3 adjust means that digit would
    // reach 10 or more on this shift: the value needs more than DIGITS digits.
    always_ff @(posedge sys_clk) begin
        if (start) begin
            bin_sr <= bin;
            bcd_sr <= '0;
            ovf_r  <= 1'b0;
        end else if (busy) begin
            bcd_sr <= {bcd_adj[4*DIGITS-2:0], bin_sr[VAL_W-1]};
            bin_sr <= bin_sr << 1;
            ovf_r  <= ovf_r | bcd_adj[4*DIGITS-1];
        end
    end

    assign bcd = bcd_sr;
    assign ovf = ovf_r;

endmodule

// File: rtl/oled_numfield.sv
// OLED numeric-field renderer: draws a binary value as DIGITS decimal 8x16
// glyphs over two SSD1306 pages, one 24-bit IIC word per transfer.
//   sys_clk, rst_n        : clock, asynchronous active-low reset
//   value_vld, value      : shadow-register load
//   show_req              : frame request (sampled in IDLE only)
//   write_done            : IIC writer accepted the current word
//   show_vld, show_data   : current transfer word {addr, ctrl, byte}
//   show_finish           : pulse with the write_done of the final word
//   glyph_code/row/col    : font ROM address (code 10 = blank)
//   glyph_byte            : font ROM data, one cycle after the address
module oled_numfield
    import oled_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int VAL_W    = 10,
    parameter int X0       = 54,
    parameter int GAP      = 0,
    parameter int PAGE     = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             value_vld,
    input  logic [VAL_W-1:0] value,
    input  logic             show_req,
    input  logic             write_done,
    output logic             show_vld,
    output logic [23:0]      show_data,
    output logic             show_finish,
    output logic [3:0]       glyph_code,
    output logic             glyph_row,
    output logic [2:0]       glyph_col,
    input  logic [7:0]       glyph_byte
);

    generate
        if (X0 + DIGITS*(GLYPH_W+GAP) - GAP > 128) begin : g_bad_geometry
            $error("oled_numfield: field does not fit in 128 columns");
        end
    endgenerate

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state;
    logic [2:0]          g;          // glyph position, 0 = leftmost (digit DIGITS-1)
    logic                row;
    logic [3:0]          w;
    logic [3:0]          codes     [DIGITS];
    logic [3:0]          codes_nxt [DIGITS];
    logic [VAL_W-1:0]    shadow;
    logic [VAL_W-1:0]    snap;
    logic                conv_start;
    logic                conv_done;
    logic                conv_ovf;
    logic [4*DIGITS-1:0] conv_bcd;
    logic [15:0]         hdr;
    logic [7:0]          cmd_byte;
    logic                data_sel;

    logic                adv;
    logic                last;
    logic [3:0]          nxt_w;
    logic                nxt_row;
    logic [2:0]          nxt_g;
    logic [3:0]          ld_w;
    logic                ld_row;
    logic [2:0]          ld_g;
    logic [3:0]          ld_code;

    function automatic logic [7:0] cmd_byte_f(input logic [3:0] wi, input logic ri,
                                              input logic [2:0] gi);
        logic [7:0] x;
        x = 8'(X0 + int'(gi) * (GLYPH_W + GAP));
        case (wi)
            4'd0:    cmd_byte_f = CMD_PAGE + 8'(PAGE) + {7'd0, ri};
            4'd1:    cmd_byte_f = CMD_COL_LO | {4'd0, x[3:0]};
            4'd2:    cmd_byte_f = CMD_COL_HI | {5'd0, x[6:4]};
            default: cmd_byte_f = 8'h00;
        endcase
    endfunction

    always_ff @(posedge sys_clk) begin
        if (value_vld) shadow <= value;
    end

    // A load in the same cycle as frame start wins over the stored shadow.
    assign snap       = value_vld ? value : shadow;
    assign conv_start = (state == IDLE) && show_req;

    bin2bcd_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .start   (conv_start),
        .bin     (snap),
        .done    (conv_done),
        .bcd     (conv_bcd),
        .ovf     (conv_ovf)
    );

    // Saturation and leading-zero blanking, scanned from the MS digit down.
    always_comb begin : lz_mask
        logic       lead;
        logic [3:0] dg;
        lead = (BLANK_LZ != 0);
        dg   = 4'd0;
        for (int i = 0; i < DIGITS; i++) codes_nxt[i] = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dg = conv_ovf ? 4'd9 : conv_bcd[4*i +: 4];
            if (lead && dg == 4'd0 && i != 0) begin
                codes_nxt[i] = GLYPH_BLANK;
            end else begin
                codes_nxt[i] = dg;
                lead         = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (state == CONV && conv_done) codes <= codes_nxt;
    end

    // Word sequencing: w 0..10, then row 0 -> 1, then next glyph.
    always_comb begin
        adv     = (state == SEND) && write_done;
        last    = (g == 3'(DIGITS - 1)) && row && (w == 4'(WORDS_PER_ROW - 1));
        nxt_w   = w + 4'd1;
        nxt_row = row;
        nxt_g   = g;
        if (w == 4'(WORDS_PER_ROW - 1)) begin
            nxt_w = 4'd0;
            if (!row) begin
                nxt_row = 1'b1;
            end else begin
                nxt_row = 1'b0;
                nxt_g   = g + 3'd1;
            end
        end
        // CONV loads the first word of the frame, SEND loads the next one.
        if (state == SEND) begin
            ld_w    = nxt_w;
            ld_row  = nxt_row;
            ld_g    = nxt_g;
            ld_code = codes[IDX_W'(DIGITS - 1 - int'(nxt_g))];
        end else begin
            ld_w    = 4'd0;
            ld_row  = 1'b0;
            ld_g    = 3'd0;
            ld_code = codes_nxt[DIGITS - 1];
        end
    end

    assign show_finish = adv && last;
    assign show_data   = {hdr, data_sel ? glyph_byte : cmd_byte};

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            g          <= 3'd0;
            row        <= 1'b0;
            w          <= 4'd0;
            show_vld   <= 1'b0;
            hdr        <= {OLED_ADDR, CTRL_CMD};
            cmd_byte   <= 8'h00;
            data_sel   <= 1'b0;
            glyph_code <= 4'd0;
            glyph_row  <= 1'b0;
            glyph_col  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (show_req) state <= CONV;
                end
                CONV, SEND: begin
                    if ((state == CONV && conv_done) || (adv && !last)) begin
                        state      <= SEND;
                        show_vld   <= 1'b1;
                        w          <= ld_w;
                        row        <= ld_row;
                        g          <= ld_g;
                        hdr        <= {OLED_ADDR, (ld_w >= 4'd3) ? CTRL_DATA : CTRL_CMD};
                        cmd_byte   <= cmd_byte_f(ld_w, ld_row, ld_g);
                        data_sel   <= (ld_w >= 4'd3);
                        glyph_code <= ld_code;
                        glyph_row  <= ld_row;
                        glyph_col  <= (ld_w >= 4'd3) ? 3'(ld_w - 4'd3) : 3'd0;
                    end else if (adv && last) begin
                        state      <= IDLE;
                        show_vld   <= 1'b0;
                        w          <= 4'd0;
                        row        <= 1'b0;
                        g          <= 3'd0;
                        hdr        <= {OLED_ADDR, CTRL_CMD};
                        cmd_byte   <= 8'h00;
                        data_sel   <= 1'b0;
                        glyph_code <= 4'd0;
                        glyph_row  <= 1'b0;
                        glyph_col  <= 3'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_numfield.sv
module tb_oled_numfield;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        req     = 1'b0;
    logic        wd      = 1'b0;
    logic        vvld    = 1'b0;
    logic        sel     = 1'b0;
    logic [10:0] val     = '0;

    logic        show_vld_a, show_finish_a, gr_a;
    logic [23:0] show_data_a;
    logic [3:0]  gc_a;
    logic [2:0]  gcol_a;
    logic [7:0]  gb_a;
    logic        show_vld_b, show_finish_b, gr_b;
    logic [23:0] show_data_b;
    logic [3:0]  gc_b;
    logic [2:0]  gcol_b;
    logic [7:0]  gb_b;

    logic        vld_m, fin_m, gr_m;
    logic [23:0] data_m;
    logic [3:0]  gc_m;
    logic [2:0]  gcol_m;

    int n_chk   = 0;
    int n_fail  = 0;
    int fin_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    // Blanking on, 10-bit value.
    oled_numfield #(.DIGITS(3), .VAL_W(10), .X0(54), .GAP(0), .PAGE(3), .BLANK_LZ(1)) u_dut_a (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .value_vld   (vvld),
        .value       (val[9:0]),
        .show_req    (req & ~sel),
        .write_done  (wd & ~sel),
        .show_vld    (show_vld_a),
        .show_data   (show_data_a),
        .show_finish (show_finish_a),
        .glyph_code  (gc_a),
        .glyph_row   (gr_a),
        .glyph_col   (gcol_a),
        .glyph_byte  (gb_a)
    );

    // Blanking off, 11-bit value so overflow inputs are representable.
    oled_numfield #(.DIGITS(3), .VAL_W(11), .X0(54), .GAP(0), .PAGE(3), .BLANK_LZ(0)) u_dut_b (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .value_vld   (vvld),
        .value       (val),
        .show_req    (req & sel),
        .write_done  (wd & sel),
        .show_vld    (show_vld_b),
        .show_data   (show_data_b),
        .show_finish (show_finish_b),
        .glyph_code  (gc_b),
        .glyph_row   (gr_b),
        .glyph_col   (gcol_b),
        .glyph_byte  (gb_b)
    );

    // Font ROM stand-in: the byte encodes its own address {code,row,col}.
    always @(posedge sys_clk) begin
        gb_a <= {gc_a, gr_a, gcol_a};
        gb_b <= {gc_b, gr_b, gcol_b};
    end

    assign vld_m  = sel ? show_vld_b    : show_vld_a;
    assign fin_m  = sel ? show_finish_b : show_finish_a;
    assign data_m = sel ? show_data_b   : show_data_a;
    assign gc_m   = sel ? gc_b          : gc_a;
    assign gr_m   = sel ? gr_b          : gr_a;
    assign gcol_m = sel ? gcol_b        : gcol_a;

    always @(posedge sys_clk) begin
        if (fin_m) fin_cnt <= fin_cnt + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word i of a DIGITS=3, X0=54, PAGE=3 frame showing glyphs {c2,c1,c0}.
    function automatic int exp_word(input int i, input logic [3:0] c2, input logic [3:0] c1,
                                    input logic [3:0] c0);
        int gi, r, wi, x, code;
        gi   = i / 22;
        r    = (i % 22) / 11;
        wi   = i % 11;
        x    = 54 + gi * 8;
        code = (gi == 0) ? int'(c2) : (gi == 1) ? int'(c1) : int'(c0);
        case (wi)
            0:       return 'h7800B0 + 3 + r;
            1:       return 'h780000 + (x % 16);
            2:       return 'h780010 + (x / 16);
            default: return 'h784000 + code * 16 + r * 8 + (wi - 3);
        endcase
    endfunction

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_vld"},  int'(vld_m),  0);
        check_eq({pfx, "_data"}, int'(data_m), 'h780000);
        check_eq({pfx, "_fin"},  int'(fin_m),  0);
        check_eq({pfx, "_code"}, int'(gc_m),   0);
        check_eq({pfx, "_row"},  int'(gr_m),   0);
        check_eq({pfx, "_col"},  int'(gcol_m), 0);
    endtask

    task automatic load(input logic [10:0] v);
        val  = v;
        vvld = 1'b1;
        @(negedge sys_clk);
        vvld = 1'b0;
    endtask

    // Runs one frame as the IIC writer would, sampling each word two cycles
    // after the previous write_done. Called right after a falling edge.
    task automatic run_frame(input logic s, input logic [3:0] c2, input logic [3:0] c1,
                             input logic [3:0] c0, input int exp_lat, input bit spur,
                             input int upd_at, input logic [10:0] upd_val,
                             input bit coinc, input logic [10:0] coinc_val,
                             input int abort_at);
        int k;
        int fin0;
        sel  = s;
        fin0 = fin_cnt;
        if (spur) begin
            repeat (2) begin
                wd = 1'b1;
                #1 check_eq("idle_spur_fin", int'(fin_m), 0);
                @(negedge sys_clk);
                wd = 1'b0;
                @(negedge sys_clk);
            end
        end
        if (coinc) begin
            val  = coinc_val;
            vvld = 1'b1;
        end
        req = 1'b1;
        k   = 0;
        do begin
            @(negedge sys_clk);
            k++;
            vvld = 1'b0;
            wd   = spur && k >= 2 && k <= 4;
            if (wd) begin
                #1 check_eq("conv_spur_fin", int'(fin_m), 0);
            end
        end while (!vld_m && k < 200);
        wd = 1'b0;
        check_eq("latency", k, exp_lat);
        if (!vld_m) begin
            req = 1'b0;
            return;
        end
        for (int i = 0; i < 66; i++) begin
            check_eq($sformatf("word%0d", i), int'(data_m), exp_word(i, c2, c1, c0));
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1 check_reset_vals("midrst");
                @(negedge sys_clk);
                rst_n = 1'b1;
                req   = 1'b0;
                return;
            end
            wd = 1'b1;
            if (i == upd_at) begin
                val  = upd_val;
                vvld = 1'b1;
            end
            if (i == 0) req = 1'b0;
            #1 check_eq($sformatf("fin%0d", i), int'(fin_m), int'(i == 65));
            @(negedge sys_clk);
            wd   = 1'b0;
            vvld = 1'b0;
            if (i < 65) @(negedge sys_clk);
        end
        check_eq("vld_after_frame", int'(vld_m), 0);
        check_eq("finish_pulses", fin_cnt - fin0, 1);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge sys_clk);

        load(11'd25);
        run_frame(1'b0, 4'd10, 4'd2, 4'd5, 12, 1'b1, -1, 11'd0, 1'b0, 11'd0, -1);
        load(11'd0);
        run_frame(1'b0, 4'd10, 4'd10, 4'd0, 12, 1'b0, -1, 11'd0, 1'b0, 11'd0, -1);
        load(11'd7);
        run_frame(1'b1, 4'd0, 4'd0, 4'd7, 13, 1'b0, -1, 11'd0, 1'b0, 11'd0, -1);
        load(11'd1500);
        run_frame(1'b1, 4'd9, 4'd9, 4'd9, 13, 1'b0, -1, 11'd0, 1'b0, 11'd0, -1);
        load(11'd1000);
        run_frame(1'b1, 4'd9, 4'd9, 4'd9, 13, 1'b0, -1, 11'd0, 1'b0, 11'd0, -1);
        load(11'd999);
        run_frame(1'b0, 4'd9, 4'd9, 4'd9, 12, 1'b0, -1, 11'd0, 1'b0, 11'd0, -1);
        load(11'd42);
        run_frame(1'b0, 4'd10, 4'd4, 4'd2, 12, 1'b0, 10, 11'd123, 1'b0, 11'd0, -1);
        run_frame(1'b0, 4'd1, 4'd2, 4'd3, 12, 1'b0, -1, 11'd0, 1'b0, 11'd0, -1);
        run_frame(1'b0, 4'd10, 4'd7, 4'd7, 12, 1'b0, -1, 11'd0, 1'b1, 11'd77, -1);
        run_frame(1'b0, 4'd10, 4'd7, 4'd7, 12, 1'b0, -1, 11'd0, 1'b0, 11'd0, 30);
        run_frame(1'b0, 4'd10, 4'd7, 4'd7, 12, 1'b0, -1, 11'd0, 1'b0, 11'd0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
